// File: rtl/image_gauss3x3_filter.sv
// Streaming 3x3 Gaussian smoother that emits interior pixels only, with a valid strobe and an end-of-frame pulse.
// Optional macro GAUSS_BYPASS_EN adds a per-pixel 'bypass' input that passes the window centre through unfiltered.
module image_gauss3x3_filter #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef GAUSS_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_en,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_en,
  output logic             frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW = PIX_W + 4;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [SW-1:0] HALF     = SW'(8);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_lb2 [IMG_W];
  logic [PIX_W-1:0] r_win [3][3];
  logic [SW-1:0]    r_sum;
  logic             r_v1, r_v2, r_f1, r_f2;

  logic [PIX_W-1:0] w_top, w_mid;
  logic             w_lastCol, w_lastRow, w_qual;
  logic [SW-1:0]    w_sum;

  assign w_top     = r_lb2[r_col];
  assign w_mid     = r_lb1[r_col];
  assign w_lastCol = (r_col == LAST_COL);
  assign w_lastRow = (r_row == LAST_ROW);
  assign w_qual    = (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_en) begin
      if (w_lastCol) begin
        r_col <= '0;
        r_row <= w_lastRow ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line buffers and window are pure datapath; stale contents are never emitted, so no reset.
  always_ff @(posedge clk) begin
    if (in_en) begin
      r_lb1[r_col] <= in_pix;
      r_lb2[r_col] <= w_mid;
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_top;
      r_win[1][2] <= w_mid;
      r_win[2][2] <= in_pix;
    end
  end

  always_comb begin
    w_sum = SW'(r_win[0][0])        + (SW'(r_win[0][1]) << 1) + SW'(r_win[0][2])
          + (SW'(r_win[1][0]) << 1) + (SW'(r_win[1][1]) << 2) + (SW'(r_win[1][2]) << 1)
          + SW'(r_win[2][0])        + (SW'(r_win[2][1]) << 1) + SW'(r_win[2][2]);
  end

`ifdef GAUSS_BYPASS_EN
  logic r_b1;

  always_ff @(posedge clk) begin
    if (in_en) r_b1 <= bypass;
  end

  // Bypass scales the centre by 16 so the shared rounding stage returns it unchanged.
  always_ff @(posedge clk) begin
    r_sum <= r_b1 ? {r_win[1][1], 4'b0000} : w_sum;
  end
`else
  always_ff @(posedge clk) begin
    r_sum <= w_sum;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_f1       <= 1'b0;
      r_f2       <= 1'b0;
      out_en     <= 1'b0;
      frame_done <= 1'b0;
      out_pix    <= '0;
    end else begin
      r_v1       <= in_en && w_qual;
      r_f1       <= in_en && w_lastRow && w_lastCol;
      r_v2       <= r_v1;
      r_f2       <= r_f1;
      out_en     <= r_v2;
      frame_done <= r_f2;
      if (r_v2) out_pix <= PIX_W'((r_sum + HALF) >> 4);
    end
  end

endmodule

// File: tb/tb_image_gauss3x3_filter.sv
// Randomized self-checking bench for image_gauss3x3_filter on a small frame, compared against a
// 2-D array convolution model that also predicts exact output timing and frame_done placement.
module tb_image_gauss3x3_filter;

  localparam int W  = 12;
  localparam int H  = 8;
  localparam int PW = 8;
  localparam int PER_FRAME = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_en;
  logic [PW-1:0] in_pix;
  logic          bypass;
  logic [PW-1:0] out_pix;
  logic          out_en;
  logic          frame_done;

  typedef struct {
    int due;
    int pix;
    int done;
    int r;
    int c;
  } exp_t;

  exp_t expQ[$];
  int   img [H][W];
  int   obs [H][W];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mRow = 0;
  int   mCol = 0;
  int   lastPix = 0;
  int   outSeen = 0;
  int   doneSeen = 0;

  image_gauss3x3_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk        (clk),
`ifdef GAUSS_BYPASS_EN
    .bypass     (bypass),
`endif
    .rst        (rst),
    .in_pix     (in_pix),
    .in_en      (in_en),
    .out_pix    (out_pix),
    .out_en     (out_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Kernel weights are 2 on the centre row/column and 1 elsewhere; bypass returns the centre.
  function automatic int refPixel(input int r, input int c, input bit byp);
    int sum = 0;
    if (byp) return img[r][c];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        sum += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[r + dr][c + dc];
    return (sum + 8) / 16;
  endfunction

  task automatic sampleOutputs();
    exp_t e;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      e = expQ.pop_front();
      checkOutput("out_en", out_en, 1);
      checkOutput("out_pix", out_pix, e.pix);
      checkOutput("frame_done", frame_done, e.done);
      lastPix = e.pix;
      obs[e.r][e.c] = out_pix;
      outSeen++;
      if (frame_done) doneSeen++;
    end else begin
      checkOutput("out_en_idle", out_en, 0);
      checkOutput("frame_done_idle", frame_done, 0);
      checkOutput("out_pix_hold", out_pix, lastPix);
      if (out_en) outSeen++;
      if (frame_done) doneSeen++;
    end
  endtask

  task automatic applyStimulus(input bit en, input int pix, input bit byp);
    exp_t e;
    in_en  = en;
    in_pix = pix[PW-1:0];
    bypass = byp;
    @(posedge clk);
    cyc++;
    if (en) begin
      img[mRow][mCol] = pix & 8'hFF;
      if (mRow >= 2 && mCol >= 2) begin
        e.due  = cyc + 2;
        e.r    = mRow - 1;
        e.c    = mCol - 1;
        e.pix  = refPixel(mRow - 1, mCol - 1, byp);
        e.done = (mRow == H - 1 && mCol == W - 1) ? 1 : 0;
        expQ.push_back(e);
      end
      if (mCol == W - 1) begin
        mCol = 0;
        mRow = (mRow == H - 1) ? 0 : mRow + 1;
      end else begin
        mCol++;
      end
    end
    #1;
    sampleOutputs();
  endtask

  task automatic doReset();
    rst   = 1'b1;
    in_en = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    expQ.delete();
    mRow    = 0;
    mCol    = 0;
    lastPix = 0;
    sampleOutputs();
  endtask

  // mode: 0 constant, 1 impulse at (5,5), 2 horizontal ramp, 3 random; gaps: 0 none, 1 toggle, 2 random.
  task automatic runPixels(input int n, input int mode, input int val, input int gaps, input bit randByp);
    int pix;
    bit byp;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       pix = val;
        1:       pix = (mRow == 5 && mCol == 5) ? 255 : 0;
        2:       pix = mCol;
        default: pix = int'($urandom_range(255));
      endcase
      byp = 1'b0;
`ifdef GAUSS_BYPASS_EN
      if (randByp) byp = 1'($urandom_range(1));
`endif
      applyStimulus(1'b1, pix, byp);
      if (gaps == 1) applyStimulus(1'b0, int'($urandom_range(255)), 1'b0);
      if (gaps == 2) while ($urandom_range(3) == 0) applyStimulus(1'b0, int'($urandom_range(255)), 1'b0);
    end
  endtask

  task automatic endTest(input string tag, input int frames);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 0, 1'b0);
    checkOutput({tag, "_count"}, outSeen, frames * PER_FRAME);
    checkOutput({tag, "_done_count"}, doneSeen, frames);
    checkOutput({tag, "_drained"}, expQ.size(), 0);
    outSeen  = 0;
    doneSeen = 0;
  endtask

  initial begin
    rst    = 1'b1;
    in_en  = 1'b0;
    in_pix = '0;
    bypass = 1'b0;
    doReset();
    checkOutput("reset_out_en", out_en, 0);
    checkOutput("reset_out_pix", out_pix, 0);

    runPixels(W * H, 0, 100, 0, 1'b0);
    endTest("const100", 1);

    runPixels(W * H, 1, 0, 0, 1'b0);
    endTest("impulse", 1);
    checkOutput("imp_centre", obs[5][5], 64);
    checkOutput("imp_up", obs[4][5], 32);
    checkOutput("imp_right", obs[5][6], 32);
    checkOutput("imp_diag", obs[6][4], 16);
    checkOutput("imp_far", obs[2][2], 0);

    runPixels(W * H, 0, 255, 0, 1'b0);
    endTest("all255", 1);

    runPixels(W * H, 2, 0, 1, 1'b0);
    endTest("ramp_toggle", 1);
    checkOutput("ramp_col3", obs[3][3], 3);

    runPixels(40, 3, 0, 2, 1'b1);
    doReset();
    checkOutput("midreset_out_en", out_en, 0);
    outSeen  = 0;
    doneSeen = 0;
    runPixels(W * H, 0, 50, 0, 1'b0);
    endTest("after_reset", 1);

    runPixels(2 * W * H, 2, 0, 0, 1'b0);
    endTest("b2b_ramp", 2);

    runPixels(3 * W * H, 3, 0, 2, 1'b1);
    endTest("random", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
